// File: rtl/flit_sender.sv
// Credit-based flit sender: pops packets from a first-word-fall-through FIFO and forwards them one flit per clock.
// Define FLIT_SENDER_STATS_EN to build the 16-bit sent-flit counter; otherwise flit_count is tied to zero.
module flit_sender #(
   parameter int CREDIT_INIT = 32,
   parameter int CNT_W       = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        fifo_empty,
   input  logic [15:0] fifo_data,
   output logic        fifo_read,
   output logic        tx_valid,
   output logic [15:0] tx_data,
   input  logic        credit_in,
   output logic        pkt_done,
   output logic        credit_err,
   output logic        busy,
   output logic [15:0] flit_count
);

   typedef enum logic {IDLE, BODY} state_t;

   localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDIT_INIT);
   localparam logic [CNT_W-1:0] CREDIT_ONE = CNT_W'(1);

   state_t           state, next_state;
   logic [3:0]       remaining, next_remaining;
   logic [CNT_W-1:0] credits;
   logic             send;
   logic             done_next;

   assign send      = reset && !fifo_empty && (credits != '0) && ((state == BODY) || enable);
   assign fifo_read = send;
   assign busy      = (state == BODY);

   always_comb begin
      next_state     = state;
      next_remaining = remaining;
      done_next      = 1'b0;
      if (send) begin
         if (state == IDLE) begin
            if (fifo_data[15:12] == 4'd0) begin
               done_next = 1'b1;
            end else begin
               next_remaining = fifo_data[15:12];
               next_state     = BODY;
            end
         end else begin
            next_remaining = remaining - 4'd1;
            if (remaining == 4'd1) begin
               done_next  = 1'b1;
               next_state = IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         remaining <= 4'd0;
         tx_valid  <= 1'b0;
         tx_data   <= 16'd0;
         pkt_done  <= 1'b0;
      end else begin
         state     <= next_state;
         remaining <= next_remaining;
         tx_valid  <= send;
         pkt_done  <= done_next;
         if (send) begin
            tx_data <= fifo_data;
         end
      end
   end

   // A credit returned while already full is dropped and flagged; a simultaneous send cancels it out.
   always_ff @(posedge clk) begin
      if (!reset) begin
         credits    <= CREDIT_MAX;
         credit_err <= 1'b0;
      end else if (send && !credit_in) begin
         credits <= credits - CREDIT_ONE;
      end else if (!send && credit_in) begin
         if (credits == CREDIT_MAX) begin
            credit_err <= 1'b1;
         end else begin
            credits <= credits + CREDIT_ONE;
         end
      end
   end

`ifdef FLIT_SENDER_STATS_EN
   logic [15:0] stat_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stat_count <= 16'd0;
      end else if (send) begin
         stat_count <= stat_count + 16'd1;
      end
   end

   assign flit_count = stat_count;
`else
   assign flit_count = 16'd0;
`endif

endmodule

// File: tb/tb_flit_sender.sv
// Self-checking bench for flit_sender: directed scenarios plus randomized traffic against a packet-level model.
module tb_flit_sender;

   localparam int CREDIT_INIT = 32;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        fifo_empty;
   logic [15:0] fifo_data;
   logic        fifo_read;
   logic        tx_valid;
   logic [15:0] tx_data;
   logic        credit_in;
   logic        pkt_done;
   logic        credit_err;
   logic        busy;
   logic [15:0] flit_count;

   flit_sender #(.CREDIT_INIT(CREDIT_INIT), .CNT_W(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_read  (fifo_read),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .credit_in  (credit_in),
      .pkt_done   (pkt_done),
      .credit_err (credit_err),
      .busy       (busy),
      .flit_count (flit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Upstream FIFO contents and packet-level reference state
   logic [15:0] fq[$];
   int   m_credits;
   int   m_left;
   bit   m_err;
   int   m_count;
   bit   exp_valid;
   bit   exp_done;
   bit   data_known;
   logic [15:0] exp_data;
   int   dut_sent;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: present FIFO head, check the pop strobe, advance the model, check registered outputs.
   task automatic applyStimulus();
      bit          exp_s;
      logic [15:0] word;
      int          len;
      @(negedge clk);
      fifo_empty = (fq.size() == 0);
      fifo_data  = fifo_empty ? 16'($urandom) : fq[0];
      #1;
      exp_s = (reset === 1'b1) && !fifo_empty && (m_credits > 0) && ((m_left > 0) || enable);
      checkOutput("fifo_read", {31'd0, fifo_read}, {31'd0, exp_s});
      word = fifo_data;
      @(posedge clk);
      if (reset !== 1'b1) begin
         m_credits  = CREDIT_INIT;
         m_left     = 0;
         m_err      = 0;
         m_count    = 0;
         exp_valid  = 0;
         exp_done   = 0;
         exp_data   = 16'd0;
         data_known = 1;
      end else begin
         exp_valid  = exp_s;
         exp_done   = 0;
         data_known = exp_s;
         if (exp_s) begin
            void'(fq.pop_front());
            exp_data = word;
            len      = int'(word[15:12]);
            if (m_left == 0) begin
               if (len == 0) exp_done = 1;
               else m_left = len;
            end else begin
               m_left = m_left - 1;
               if (m_left == 0) exp_done = 1;
            end
            m_count = (m_count + 1) % 65536;
         end
         m_credits = m_credits + int'(credit_in) - int'(exp_s);
         if (m_credits > CREDIT_INIT) begin
            m_credits = CREDIT_INIT;
            m_err     = 1;
         end
      end
      #1;
      if (tx_valid === 1'b1) dut_sent++;
      checkOutput("tx_valid", {31'd0, tx_valid}, {31'd0, exp_valid});
      if (data_known) checkOutput("tx_data", {16'd0, tx_data}, {16'd0, exp_data});
      checkOutput("pkt_done", {31'd0, pkt_done}, {31'd0, exp_done});
      checkOutput("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      checkOutput("credit_err", {31'd0, credit_err}, {31'd0, m_err});
`ifdef FLIT_SENDER_STATS_EN
      checkOutput("flit_count", {16'd0, flit_count}, 32'(m_count));
`else
      checkOutput("flit_count", {16'd0, flit_count}, 32'd0);
`endif
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   task automatic doReset();
      reset     = 1'b0;
      credit_in = 1'b0;
      runCycles(2);
      reset     = 1'b1;
   endtask

   task automatic pushRandomPacket();
      int len;
      len = $urandom_range(0, 15);
      fq.push_back({4'(len), 12'($urandom)});
      for (int i = 0; i < len; i++) fq.push_back(16'($urandom));
   endtask

   initial begin
      reset      = 1'b0;
      enable     = 1'b0;
      credit_in  = 1'b0;
      fifo_empty = 1'b1;
      fifo_data  = 16'd0;
      m_credits  = CREDIT_INIT;
      m_left     = 0;
      m_err      = 0;
      m_count    = 0;
      exp_valid  = 0;
      exp_done   = 0;
      exp_data   = 16'd0;
      data_known = 0;
      dut_sent   = 0;

      // Reset with a non-empty FIFO: nothing may be popped
      fq.push_back(16'h1234);
      doReset();
      fq.delete();

      // Three-flit packet straight through
      fq.push_back(16'h2000);
      fq.push_back(16'h0001);
      fq.push_back(16'h0002);
      enable   = 1'b1;
      dut_sent = 0;
      runCycles(5);
      checkOutput("pkt3_sent", 32'(dut_sent), 32'd3);

      // Credit exhaustion, then a single returned credit
      doReset();
      for (int i = 0; i < 40; i++) fq.push_back(16'h0000);
      dut_sent = 0;
      runCycles(40);
      checkOutput("credit_limit_sent", 32'(dut_sent), 32'd32);
      credit_in = 1'b1;
      runCycles(1);
      credit_in = 1'b0;
      runCycles(4);
      checkOutput("one_credit_sent", 32'(dut_sent), 32'd33);

      // Send and credit in the same cycle at five credits
      doReset();
      fq.delete();
      for (int i = 0; i < 28; i++) fq.push_back(16'h0000);
      runCycles(27);
      credit_in = 1'b1;
      runCycles(1);
      credit_in = 1'b0;
      for (int i = 0; i < 10; i++) fq.push_back(16'h0000);
      dut_sent = 0;
      runCycles(12);
      checkOutput("five_credits_sent", 32'(dut_sent), 32'd5);

      // Credit returned while full
      doReset();
      fq.delete();
      credit_in = 1'b1;
      runCycles(1);
      credit_in = 1'b0;
      runCycles(3);
      checkOutput("credit_err_sticky", {31'd0, credit_err}, 32'd1);
      doReset();

      // A started packet completes after enable drops; the next head waits
      fq.push_back(16'h3000);
      enable = 1'b1;
      runCycles(1);
      enable = 1'b0;
      fq.push_back(16'h00A1);
      fq.push_back(16'h00A2);
      fq.push_back(16'h00A3);
      fq.push_back(16'h0000);
      dut_sent = 0;
      runCycles(6);
      checkOutput("body_without_enable", 32'(dut_sent), 32'd3);
      enable = 1'b1;
      runCycles(2);
      checkOutput("head_after_enable", 32'(dut_sent), 32'd4);

      // Reset mid-packet, then a len-0 head
      doReset();
      fq.delete();
      fq.push_back(16'h5000);
      fq.push_back(16'h0001);
      fq.push_back(16'h0002);
      runCycles(3);
      fq.delete();
      fq.push_back(16'h0ABC);
      reset = 1'b0;
      runCycles(1);
      reset = 1'b1;
      runCycles(1);
      checkOutput("after_reset_head", {16'd0, tx_data}, 32'h0ABC);
      checkOutput("after_reset_done", {31'd0, pkt_done}, 32'd1);

      // Randomized traffic with credits, enable and occasional resets
      doReset();
      fq.delete();
      for (int i = 0; i < 3000; i++) begin
         if (fq.size() < 4) pushRandomPacket();
         enable    = ($urandom_range(0, 3) != 0);
         credit_in = ($urandom_range(0, 2) == 0);
         reset     = ($urandom_range(0, 199) != 0);
         applyStimulus();
      end
      reset     = 1'b1;
      credit_in = 1'b0;

      // Long stream to exercise the statistics counter wrap
      doReset();
      fq.delete();
      enable    = 1'b1;
      credit_in = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         if (fq.size() == 0) fq.push_back(16'h0000);
         applyStimulus();
      end
      credit_in = 1'b0;
`ifdef FLIT_SENDER_STATS_EN
      checkOutput("flit_count_wrap", {16'd0, flit_count}, 32'd4464);
`else
      checkOutput("flit_count_off", {16'd0, flit_count}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
